vec_data_mem_loader: RTL and testbench

//  Host-side writer for VecDataMem: accepts a 32-bit word stream (valid/ready), packs WIDTH words

---
 rtl/vec_data_mem_loader_if.sv | 29 ++
 rtl/vec_data_mem_loader.sv | 171 +++++++++++++++++
 tb/tb_vec_data_mem_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vec_data_mem_loader_if.sv
// Host-to-loader bundle: load control, 32-bit word stream (valid/ready) and the data-memory write port.
// master = host/stream side, slave = the loader itself.
interface vec_data_mem_loader_if #(
  parameter int WIDTH              = 16,
  parameter int DATA_MEM_ADDR_SIZE = 32
);
  logic                          start;
  logic [DATA_MEM_ADDR_SIZE-1:0] base_addr;
  logic [DATA_MEM_ADDR_SIZE-1:0] num_vecs;
  logic                          in_valid;
  logic [31:0]                   in_data;
  logic                          in_ready;
  logic                          mem_wr_en;
  logic [DATA_MEM_ADDR_SIZE-1:0] mem_wr_addr;
  logic [32*WIDTH-1:0]           mem_wr_data;
  logic                          busy;
  logic                          done;
  logic                          error;

  modport master (
    output start, base_addr, num_vecs, in_valid, in_data,
    input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done, error
  );

  modport slave (
    input  start, base_addr, num_vecs, in_valid, in_data,
    output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done, error
  );
endinterface

// File: rtl/vec_data_mem_loader.sv
// Packs WIDTH stream words per vector and writes one VecDataMem row per vector: WIDTH+1 cycles/vector, done 1 cycle after last write.
// in_ready is high only in FILL; optional VEC_LOADER_BOUNDS_CHECK_EN rejects loads running past DATA_MEM_SIZE rows.
module vec_data_mem_loader #(
  parameter int WIDTH              = 16,
  parameter int DATA_MEM_SIZE      = 2048,
  parameter int DATA_MEM_ADDR_SIZE = 32,
  parameter int LANE_ADDR_SIZE     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  vec_data_mem_loader_if.slave bus
);

  localparam int AW = DATA_MEM_ADDR_SIZE;
  localparam logic [LANE_ADDR_SIZE-1:0] LAST_LANE = LANE_ADDR_SIZE'(WIDTH - 1);

  if (WIDTH < 1 || DATA_MEM_SIZE < 1 || DATA_MEM_ADDR_SIZE < 1) begin : g_bad_params
    $error("vec_data_mem_loader: WIDTH, DATA_MEM_SIZE and DATA_MEM_ADDR_SIZE must be positive");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0]                 base_q;
  logic [AW-1:0]                 num_q;
  logic [AW-1:0]                 vec_idx;
  logic [LANE_ADDR_SIZE-1:0]     lane_idx;
  logic [WIDTH-1:0][31:0]        lanes;

  logic in_ready_c;
  logic wr_en_c;
  logic busy_c;
  logic done_c;

  logic handshake;
  logic last_lane;
  logic last_vec;
  logic bounds_fail;

  assign handshake = bus.in_valid & in_ready_c;
  assign last_lane = (lane_idx == LAST_LANE);
  assign last_vec  = ((vec_idx + AW'(1)) == num_q);

`ifdef VEC_LOADER_BOUNDS_CHECK_EN
  // One extra bit so a load ending exactly at the top of the address space cannot wrap into range.
  localparam logic [AW:0] MEM_ROWS = (AW + 1)'(DATA_MEM_SIZE);
  logic [AW:0] load_end;
  logic        error_q;

  assign load_end    = {1'b0, bus.base_addr} + {1'b0, bus.num_vecs};
  assign bounds_fail = (load_end > MEM_ROWS);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      error_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      error_q <= bounds_fail;
    end
  end

  assign bus.error = error_q;
`else
  assign bounds_fail = 1'b0;
  assign bus.error   = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bounds_fail || bus.num_vecs == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = FILL;
          end
        end
      end
      FILL: begin
        if (handshake && last_lane) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        state_nxt = last_vec ? DONE : FILL;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = 1'b0;
    wr_en_c    = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    unique case (state)
      FILL: begin
        busy_c     = 1'b1;
        in_ready_c = 1'b1;
      end
      WRITE: begin
        busy_c  = 1'b1;
        wr_en_c = 1'b1;
      end
      DONE: begin
        done_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Load parameters are captured only in IDLE, so a mid-load start or base/num change has no effect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base_q   <= '0;
      num_q    <= '0;
      vec_idx  <= '0;
      lane_idx <= '0;
      lanes    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            base_q   <= bus.base_addr;
            num_q    <= bus.num_vecs;
            vec_idx  <= '0;
            lane_idx <= '0;
          end
        end
        FILL: begin
          if (handshake) begin
            lanes[lane_idx] <= bus.in_data;
            lane_idx        <= last_lane ? '0 : lane_idx + LANE_ADDR_SIZE'(1);
          end
        end
        WRITE: begin
          vec_idx  <= vec_idx + AW'(1);
          lane_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  // Write address/data are forced to zero outside WRITE so the bus is quiet between rows.
  assign bus.in_ready    = in_ready_c;
  assign bus.mem_wr_en   = wr_en_c;
  assign bus.mem_wr_addr = wr_en_c ? (base_q + vec_idx) : '0;
  assign bus.mem_wr_data = wr_en_c ? lanes : '0;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;

endmodule

// File: tb/tb_vec_data_mem_loader.sv
// Bench for vec_data_mem_loader (WIDTH=4, 16 rows, 8-bit addresses): table rows, directed corner sequences, random loads vs a row-list model.
module tb_vec_data_mem_loader;
  localparam int W  = 4;
  localparam int SZ = 16;
  localparam int AW = 8;
  localparam int VW = 32 * W;
`ifdef VEC_LOADER_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  vec_data_mem_loader_if #(.WIDTH(W), .DATA_MEM_ADDR_SIZE(AW)) bus ();

  vec_data_mem_loader #(
    .WIDTH(W), .DATA_MEM_SIZE(SZ), .DATA_MEM_ADDR_SIZE(AW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_seen = 0;
  int done_cyc = 0;
  int rdy_cnt = 0;
  logic [AW-1:0] wr_addr_q[$];
  logic [VW-1:0] wr_data_q[$];
  logic [31:0]   acc_q[$];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (bus.mem_wr_en) begin
      wr_addr_q.push_back(bus.mem_wr_addr);
      wr_data_q.push_back(bus.mem_wr_data);
    end
    if (bus.done) begin
      done_seen++;
      done_cyc = cyc;
    end
    if (bus.in_ready) rdy_cnt++;
    if (bus.in_valid && bus.in_ready) acc_q.push_back(bus.in_data);
  end

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one complete load and compares everything the DUT produced against the row-list model.
  task automatic run_load(input logic [AW-1:0] base, input logic [AW-1:0] num, input int gap,
                          input bit seq, output int n_wr, output int lat, output bit err_o);
    logic [31:0]   words[$];
    logic [VW-1:0] exp_data;
    bit            exp_err;
    int            total, sent, budget, start_cyc;
    bit            phase, v, hs;

    wr_addr_q.delete(); wr_data_q.delete(); acc_q.delete();
    done_seen = 0;
    rdy_cnt   = 0;
    exp_err = BOUNDS && (int'(base) + int'(num) > SZ);
    total   = exp_err ? 0 : int'(num) * W;
    for (int i = 0; i < total; i++) words.push_back(seq ? 32'(i + 1) : $urandom);

    bus.base_addr = base;
    bus.num_vecs  = num;
    bus.start     = 1'b1;
    start_cyc     = cyc;
    @(posedge clock); #1;
    bus.start = 1'b0;

    sent = 0; budget = 0; phase = 1'b0;
    while (sent < total && budget < 400) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = phase;
        default: v = 1'($urandom_range(0, 1));
      endcase
      phase         = ~phase;
      bus.in_valid  = v;
      bus.in_data   = v ? words[sent] : $urandom;
      bus.start     = (gap == 1);
      bus.base_addr = (gap == 1) ? 8'h77 : base;
      hs = v && bus.in_ready;
      @(posedge clock); #1;
      if (hs) sent++;
      budget++;
    end
    bus.in_valid  = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = base;
    if (sent < total) check_int("stream_timeout", sent, total);

    budget = 0;
    while (done_seen == 0 && budget < 50) begin
      @(posedge clock); #1;
      budget++;
    end
    if (done_seen == 0) check_int("done_timeout", 0, 1);
    lat = done_cyc - start_cyc;
    @(posedge clock); #1;

    n_wr  = wr_addr_q.size();
    err_o = bus.error;
    check_int("nwrites", n_wr, exp_err ? 0 : int'(num));
    for (int vi = 0; vi < n_wr && vi < int'(num); vi++) begin
      for (int l = 0; l < W; l++) exp_data[32*l +: 32] = words[vi*W + l];
      check_int("wr_addr", int'(wr_addr_q[vi]), (int'(base) + vi) % 256);
      check_vec("wr_data", wr_data_q[vi], exp_data);
    end
    check_int("accepted", acc_q.size(), total);
    check_int("error", int'(bus.error), int'(exp_err));
    check_int("done_pulse", done_seen * 2 + int'(bus.done), 2);
    check_int("busy_after", int'(bus.busy), 0);
    if (gap == 0) check_int("latency", lat, exp_err ? 1 : 1 + int'(num) * (W + 1));
    if (total == 0) check_int("rdy_idle", rdy_cnt, 0);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] num;
    int            gap;
    int            exp_writes;
    int            exp_latency;
    bit            exp_err;
  } vec_t;

  vec_t tbl[6];
  int   n_wr, lat;
  bit   err;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'd3,  8'd2, 1, 2, -1, 1'b0};
    tbl[1] = '{8'd0,  8'd0, 0, 0,  1, 1'b0};
`ifdef VEC_LOADER_BOUNDS_CHECK_EN
    tbl[2] = '{8'd15, 8'd2, 0, 0,  1, 1'b1};
`else
    tbl[2] = '{8'hFF, 8'd2, 0, 2, 11, 1'b0};
`endif
    tbl[3] = '{8'd14, 8'd2, 0, 2, 11, 1'b0};
    tbl[4] = '{8'd7,  8'd3, 2, 3, -1, 1'b0};
    tbl[5] = '{8'd0,  8'd1, 0, 1,  6, 1'b0};

    reset = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.num_vecs = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) @(posedge clock);
    #1;
    check_int("rst_busy", int'(bus.busy), 0);
    check_int("rst_ready", int'(bus.in_ready), 0);
    check_int("rst_wr_en", int'(bus.mem_wr_en), 0);
    check_int("rst_done", int'(bus.done), 0);
    check_int("rst_error", int'(bus.error), 0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Back-to-back 0x1..0x8 into rows 3 and 4.
    run_load(8'd3, 8'd2, 0, 1'b1, n_wr, lat, err);
    check_int("t1_latency", lat, 11);
    if (wr_data_q.size() == 2) begin
      check_int("t1_addr0", int'(wr_addr_q[0]), 3);
      check_int("t1_addr1", int'(wr_addr_q[1]), 4);
      check_vec("t1_row3", wr_data_q[0], 128'h00000004_00000003_00000002_00000001);
      check_vec("t1_row4", wr_data_q[1], 128'h00000008_00000007_00000006_00000005);
    end else begin
      check_int("t1_rows", wr_data_q.size(), 2);
    end

    for (int i = 0; i < 6; i++) begin
      run_load(tbl[i].base, tbl[i].num, tbl[i].gap, 1'b1, n_wr, lat, err);
      check_int($sformatf("tbl%0d_writes", i), n_wr, tbl[i].exp_writes);
      check_int($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].exp_err));
      if (tbl[i].exp_latency >= 0) check_int($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_latency);
    end

    // Reset in the middle of vector 0 must drop the partial vector without a write.
    wr_addr_q.delete(); wr_data_q.delete();
    bus.base_addr = 8'd5; bus.num_vecs = 8'd1; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.in_data = 32'hDEAD_0000 + 32'(k);
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_int("mid_rst_busy", int'(bus.busy), 0);
    check_int("mid_rst_ready", int'(bus.in_ready), 0);
    check_int("mid_rst_wr_en", int'(bus.mem_wr_en), 0);
    check_int("mid_rst_addr", int'(bus.mem_wr_addr), 0);
    check_vec("mid_rst_data", bus.mem_wr_data, '0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_int("mid_rst_nowrite", wr_addr_q.size(), 0);
    run_load(8'd0, 8'd1, 0, 1'b0, n_wr, lat, err);
    check_int("post_rst_writes", n_wr, 1);

    for (int r = 0; r < 10; r++) begin
      logic [AW-1:0] b, n;
      b = BOUNDS ? AW'($urandom_range(0, 16)) : AW'($urandom_range(0, 255));
      n = AW'($urandom_range(0, 3));
      run_load(b, n, 2, 1'b0, n_wr, lat, err);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
